// File: rtl/prng_pkg.sv
// Shared definitions for the 4-bit universal shift-register PRNG and its checker.
package prng_pkg;

  localparam int unsigned PRNG_WIDTH = 4;
  localparam logic [PRNG_WIDTH-1:0] PRNG_TAPS = 4'b0011;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } chk_state_e;

endpackage

// File: rtl/prng_predictor.sv
// History shift register mirroring the generator state, plus the next-bit XOR tree.
module prng_predictor
  import prng_pkg::*;
#(
  parameter int unsigned           WIDTH = PRNG_WIDTH,
  parameter logic [WIDTH-1:0]      TAPS  = WIDTH'(PRNG_TAPS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [WIDTH-1:0] hist,
  output logic             pred_c
);

  // Received bits enter at the top; hist[0] is the oldest bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '0;
    end else if (clear) begin
      hist <= '0;
    end else if (shift_en) begin
      hist <= {bit_in, hist[WIDTH-1:1]};
    end
  end

  // Prediction for the next valid bit from the registered history.
  assign pred_c = ^(hist & TAPS);

endmodule

// File: rtl/prng_seq_checker.sv
// Receive-side checker: seeds from the stream, predicts each bit, tracks lock and errors.
module prng_seq_checker
  import prng_pkg::*;
#(
  parameter int unsigned      WIDTH    = PRNG_WIDTH,
  parameter logic [WIDTH-1:0] TAPS     = WIDTH'(PRNG_TAPS),
  parameter int unsigned      LOCK_CNT = 8,
  parameter int unsigned      LOSS_CNT = 3,
  parameter int unsigned      CW       = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          bit_valid,
  input  logic          bit_in,
  output logic [1:0]    state,
  output logic          locked,
  output logic          err_pulse,
  output logic          zero_lock,
  output logic          pred_bit,
  output logic [CW-1:0] err_count,
  output logic [CW-1:0] bit_count
);

  localparam int unsigned FW  = $clog2(WIDTH + 1);
  localparam int unsigned OKW = $clog2(LOCK_CNT + 1);
  localparam int unsigned EW  = $clog2(LOSS_CNT + 1);

  chk_state_e       st_q, st_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [OKW-1:0]   ok_q, ok_d;
  logic [EW-1:0]    bad_q, bad_d;
  logic [WIDTH-1:0] hist;
  logic             pred_c;
  logic             take_c;
  logic             compare_c;
  logic             mismatch_c;

  assign take_c     = bit_valid && !clear;
  assign compare_c  = take_c && (st_q != ST_HUNT);
  assign mismatch_c = bit_in ^ pred_c;

  prng_predictor #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_pred (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .shift_en (take_c),
    .bit_in   (bit_in),
    .hist     (hist),
    .pred_c   (pred_c)
  );

  // FSM state and run counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= ST_HUNT;
      fill_q <= '0;
      ok_q   <= '0;
      bad_q  <= '0;
    end else begin
      st_q   <= st_d;
      fill_q <= fill_d;
      ok_q   <= ok_d;
      bad_q  <= bad_d;
    end
  end

  // Next state: fill in HUNT, count good runs in SYNC, count bad runs in LOCKED.
  always_comb begin
    st_d   = st_q;
    fill_d = fill_q;
    ok_d   = ok_q;
    bad_d  = bad_q;
    if (bit_valid) begin
      unique case (st_q)
        ST_HUNT: begin
          if (fill_q == FW'(WIDTH - 1)) begin
            st_d   = ST_SYNC;
            fill_d = '0;
            ok_d   = '0;
          end else begin
            fill_d = fill_q + FW'(1);
          end
        end
        ST_SYNC: begin
          if (mismatch_c) begin
            ok_d = '0;
          end else if (ok_q == OKW'(LOCK_CNT - 1)) begin
            st_d  = ST_LOCKED;
            ok_d  = '0;
            bad_d = '0;
          end else begin
            ok_d = ok_q + OKW'(1);
          end
        end
        ST_LOCKED: begin
          if (!mismatch_c) begin
            bad_d = '0;
          end else if (bad_q == EW'(LOSS_CNT - 1)) begin
            st_d   = ST_HUNT;
            fill_d = '0;
            bad_d  = '0;
          end else begin
            bad_d = bad_q + EW'(1);
          end
        end
        default: st_d = ST_HUNT;
      endcase
    end
    if (clear) begin
      st_d   = ST_HUNT;
      fill_d = '0;
      ok_d   = '0;
      bad_d  = '0;
    end
  end

  // Error pulse and saturating totals over compared bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse <= 1'b0;
      err_count <= '0;
      bit_count <= '0;
    end else if (clear) begin
      err_pulse <= 1'b0;
      err_count <= '0;
      bit_count <= '0;
    end else begin
      err_pulse <= compare_c && mismatch_c;
      if (compare_c && (bit_count != {CW{1'b1}})) begin
        bit_count <= bit_count + CW'(1);
      end
      if (compare_c && mismatch_c && (err_count != {CW{1'b1}})) begin
        err_count <= err_count + CW'(1);
      end
    end
  end

  assign state     = st_q;
  assign locked    = (st_q == ST_LOCKED);
  assign zero_lock = (st_q != ST_HUNT) && (hist == '0);
  assign pred_bit  = pred_c;

endmodule

// File: tb/tb_prng_seq_checker.sv
// Scoreboard bench for prng_seq_checker: directed streams with hand-derived expectations.
module tb_prng_seq_checker;

  localparam logic [1:0] H = 2'd0;
  localparam logic [1:0] S = 2'd1;
  localparam logic [1:0] L = 2'd2;

  typedef struct {
    int         ph;
    int         idx;
    bit         probe;
    logic [1:0] st;
    logic       ep;
    logic       zl;
    logic       pr;
    bit         pr_chk;
    logic [15:0] ec;
    logic [15:0] bc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        bit_valid = 1'b0;
  logic        bit_in = 1'b0;
  logic        bv_d = 1'b0;

  logic [1:0]  state;
  logic        locked, err_pulse, zero_lock, pred_bit;
  logic [15:0] err_count, bit_count;
  logic [1:0]  s_state;
  logic        s_locked, s_err_pulse, s_zero_lock, s_pred_bit;
  logic [3:0]  s_err_count, s_bit_count;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  // Generator output from seed 4'b1000, one period.
  logic seq [15] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1,
                     1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  prng_seq_checker u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .bit_valid (bit_valid),
    .bit_in    (bit_in),
    .state     (state),
    .locked    (locked),
    .err_pulse (err_pulse),
    .zero_lock (zero_lock),
    .pred_bit  (pred_bit),
    .err_count (err_count),
    .bit_count (bit_count)
  );

  prng_seq_checker #(.CW(4)) u_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .bit_valid (bit_valid),
    .bit_in    (bit_in),
    .state     (s_state),
    .locked    (s_locked),
    .err_pulse (s_err_pulse),
    .zero_lock (s_zero_lock),
    .pred_bit  (s_pred_bit),
    .err_count (s_err_count),
    .bit_count (s_bit_count)
  );

  always #5 clk = ~clk;

  // Marks cycles where the DUT has just consumed a bit.
  always @(posedge clk) bv_d <= bit_valid && !clear;

  task automatic chk(input string nm, input int ph, input int idx,
                     input logic [15:0] act, input logic [15:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s phase=%0d bit=%0d actual=%0h expected=%0h", nm, ph, idx, act, exp_v);
    end
  endtask

  // Monitor: pop one expectation per consumed bit, or a pending probe.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() != 0 && (sb_q[0].probe || bv_d)) begin
      e = sb_q.pop_front();
      chk("state",      e.ph, e.idx, 16'(state),     16'(e.st));
      chk("locked",     e.ph, e.idx, 16'(locked),    16'(e.st == L));
      chk("err_pulse",  e.ph, e.idx, 16'(err_pulse), 16'(e.ep));
      chk("zero_lock",  e.ph, e.idx, 16'(zero_lock), 16'(e.zl));
      chk("err_count",  e.ph, e.idx, err_count,      e.ec);
      chk("bit_count",  e.ph, e.idx, bit_count,      e.bc);
      chk("cw4_state",  e.ph, e.idx, 16'(s_state),     16'(e.st));
      chk("cw4_locked", e.ph, e.idx, 16'(s_locked),    16'(e.st == L));
      chk("cw4_pulse",  e.ph, e.idx, 16'(s_err_pulse), 16'(e.ep));
      chk("cw4_zero",   e.ph, e.idx, 16'(s_zero_lock), 16'(e.zl));
      chk("cw4_errcnt", e.ph, e.idx, 16'(s_err_count), e.ec);
      chk("cw4_bitcnt", e.ph, e.idx, 16'(s_bit_count), (e.bc > 16'd15) ? 16'd15 : e.bc);
      if (e.pr_chk) begin
        chk("pred_bit",     e.ph, e.idx, 16'(pred_bit),   16'(e.pr));
        chk("cw4_pred_bit", e.ph, e.idx, 16'(s_pred_bit), 16'(e.pr));
      end
    end else if (bv_d) begin
      n_chk++;
      n_fail++;
      $display("FAIL spurious_output actual=output_present required=no_pending_expectation");
    end
  end

  task automatic drain();
    bit_valid = 1'b0;
    for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(negedge clk);
    if (sb_q.size() != 0) begin
      $display("FAIL drain_timeout actual=%0d pending required=0", sb_q.size());
      $fatal(1);
    end
  endtask

  task automatic send(input logic b, input int ph, input int idx, input logic [1:0] st,
                      input logic ep, input logic zl, input logic pr, input bit prc,
                      input int ec, input int bc);
    exp_t e;
    e.ph = ph; e.idx = idx; e.probe = 1'b0; e.st = st; e.ep = ep; e.zl = zl;
    e.pr = pr; e.pr_chk = prc; e.ec = 16'(ec); e.bc = 16'(bc);
    bit_valid = 1'b1;
    bit_in = b;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic probe(input int ph, input logic [1:0] st, input logic zl, input logic pr,
                       input int ec, input int bc);
    exp_t e;
    e.ph = ph; e.idx = -1; e.probe = 1'b1; e.st = st; e.ep = 1'b0; e.zl = zl;
    e.pr = pr; e.pr_chk = 1'b1; e.ec = 16'(ec); e.bc = 16'(bc);
    sb_q.push_back(e);
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] st;
    logic       b;
    int         ec, bc;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    probe(0, H, 1'b0, 1'b0, 0, 0);

    // Clean lock, then a single inverted bit at index 20.
    for (int i = 0; i < 40; i++) begin
      b  = seq[i % 15];
      if (i == 20) b = ~b;
      st = (i < 3) ? H : (i < 11) ? S : L;
      bc = (i >= 4) ? i - 3 : 0;
      ec = (i < 20) ? 0 : (i < 23) ? 1 : (i < 24) ? 2 : 3;
      send(b, 1, i, st, (i == 20 || i == 23 || i == 24), 1'b0, seq[(i + 1) % 15],
           (st != H) && !(i >= 20 && i <= 23), ec, bc);
    end
    drain();

    // bit_valid held low: nothing moves.
    probe(2, L, 1'b0, seq[10], 3, 36);
    repeat (10) @(posedge clk);
    probe(3, L, 1'b0, seq[10], 3, 36);

    // clear together with bit_valid: restart, bit discarded.
    @(posedge clk);
    #1 clear = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0; bit_valid = 1'b0;
    probe(4, H, 1'b0, 1'b0, 0, 0);

    // Loss of lock on three consecutive inverted bits, then relock.
    for (int i = 0; i < 40; i++) begin
      b  = seq[i % 15];
      if (i >= 20 && i <= 22) b = ~b;
      st = (i < 3) ? H : (i < 11) ? S : (i < 22) ? L : (i < 26) ? H : (i < 34) ? S : L;
      bc = (i < 4) ? 0 : (i <= 22) ? i - 3 : (i <= 26) ? 19 : i - 7;
      ec = (i < 20) ? 0 : (i == 20) ? 1 : (i == 21) ? 2 : 3;
      send(b, 5, i, st, (i >= 20 && i <= 22), 1'b0, seq[(i + 1) % 15],
           (st != H) && !(i >= 20 && i <= 25), ec, bc);
    end
    drain();

    // Asynchronous reset between edges while locked.
    @(posedge clk);
    #3 rst_n = 1'b0;
    probe(6, H, 1'b0, 1'b0, 0, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Stuck generator: all zeros locks, with zero_lock raised.
    for (int i = 0; i < 12; i++) begin
      st = (i < 3) ? H : (i < 11) ? S : L;
      send(1'b0, 7, i, st, 1'b0, (st != H), 1'b0, (st != H), 0, (i >= 4) ? i - 3 : 0);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
